mem_arbiter: RTL and testbench

Arbiter and sequencer sharing one single-ported, fixed-latency memory between the fetch stage (instruction side) and the memory stage (data side) for a unified-memory build of the processor. It accepts level-held requests from both sides and grants exactly one transaction at a time. It drives the memory, counts the access latency, and returns read data to the granted side with a one-cycle done pulse. Fetch uses `if_done` in place of an always-ready instruction memory and holds the PC until the pulse arrives.

---
 rtl/mem_arbiter_if.sv | 38 +++
 rtl/mem_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and memory bus bundle for mem_arbiter
interface mem_arbiter_if;
    // instruction side
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_done;
    logic [15:0] if_data;
    // data side
    logic        d_req;
    logic        d_wr;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_done;
    logic [15:0] d_rdata;
    // shared memory port
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    // status
    logic        busy;
    logic        err;

    // arbiter view
    modport slave (
        input  if_req, if_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
        output if_done, if_data, d_done, d_rdata,
        output mem_en, mem_wr, mem_addr, mem_wdata, busy, err
    );

    // requesters plus memory view
    modport master (
        output if_req, if_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
        input  if_done, if_data, d_done, d_rdata,
        input  mem_en, mem_wr, mem_addr, mem_wdata, busy, err
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter for one fixed-latency memory; MEM_ARB_RR_EN selects round-robin ties
module mem_arbiter #(
    parameter int MEM_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    localparam logic [2:0] LAT = 3'(MEM_LAT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  cnt;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic        wr_q;
    logic        grant_i;
    logic        grant_d;
    logic        last_cycle;
    logic        if_done_q;
    logic        d_done_q;
    logic [15:0] if_data_q;
    logic [15:0] d_rdata_q;
    logic        err_q;

`ifdef MEM_ARB_RR_EN
    logic last_d;

    // tie goes to whichever side was not served last
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state == IDLE) begin
            if (bus.d_req && bus.if_req) begin
                grant_d = !last_d;
                grant_i = last_d;
            end else begin
                grant_d = bus.d_req;
                grant_i = bus.if_req;
            end
        end
    end

    // remember the side granted most recently (reset value: instruction)
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_d <= 1'b0;
        end else if (grant_d) begin
            last_d <= 1'b1;
        end else if (grant_i) begin
            last_d <= 1'b0;
        end
    end
`else
    // fixed priority: data side always wins a tie
    always_comb begin
        grant_d = (state == IDLE) && bus.d_req;
        grant_i = (state == IDLE) && bus.if_req && !bus.d_req;
    end
`endif

    assign last_cycle = (state != IDLE) && (cnt == LAT);

    // state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state: grant from IDLE, return once the latency has elapsed
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    state_nxt = BUSY_D;
                end else if (grant_i) begin
                    state_nxt = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (last_cycle) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // latency counter: 1 in the mem_en cycle, counts up to MEM_LAT
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= 3'd0;
        end else if (grant_d || grant_i) begin
            cnt <= 3'd1;
        end else if (last_cycle) begin
            cnt <= 3'd0;
        end else if (state != IDLE) begin
            cnt <= cnt + 3'd1;
        end
    end

    // capture the granted request; the memory port is driven only from here
    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_q  <= 16'h0000;
            wdata_q <= 16'h0000;
            wr_q    <= 1'b0;
        end else if (grant_d) begin
            addr_q  <= bus.d_addr;
            wdata_q <= bus.d_wdata;
            wr_q    <= bus.d_wr;
        end else if (grant_i) begin
            addr_q  <= bus.if_addr;
            wr_q    <= 1'b0;
        end
    end

    // completion: sample read data on the final edge and pulse done
    always_ff @(posedge clk) begin
        if (!rst) begin
            if_done_q <= 1'b0;
            d_done_q  <= 1'b0;
            if_data_q <= 16'h0000;
            d_rdata_q <= 16'h0000;
        end else begin
            if_done_q <= last_cycle && (state == BUSY_I);
            d_done_q  <= last_cycle && (state == BUSY_D);
            if (last_cycle && (state == BUSY_I)) begin
                if_data_q <= bus.mem_rdata;
            end
            if (last_cycle && (state == BUSY_D) && !wr_q) begin
                d_rdata_q <= bus.mem_rdata;
            end
        end
    end

    // sticky flag: granted requester let go of req before its done
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (((state == BUSY_I) && !bus.if_req) ||
                     ((state == BUSY_D) && !bus.d_req)) begin
            err_q <= 1'b1;
        end
    end

    assign bus.mem_en    = (state != IDLE) && (cnt == 3'd1);
    assign bus.mem_wr    = bus.mem_en && wr_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.if_done   = if_done_q;
    assign bus.if_data   = if_data_q;
    assign bus.d_done    = d_done_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.busy      = (state != IDLE);
    assign bus.err       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter against a transaction-level model
module tb_mem_arbiter;

    localparam int LAT = 2;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
    } req_t;

    logic clk = 1'b0;
    logic rst;
    mem_arbiter_if bus ();

    mem_arbiter #(.MEM_LAT(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // external memory: combinational read of the held address, write on mem_en
    logic [15:0] mem_arr [16] = '{16'hABCD, 16'h0101, 16'h0202, 16'h0303,
                                  16'h0404, 16'h0505, 16'h0606, 16'h0707,
                                  16'h0808, 16'h0909, 16'h0A0A, 16'h0B0B,
                                  16'h0C0C, 16'h0D0D, 16'h0E0E, 16'h0F0F};
    assign bus.mem_rdata = mem_arr[bus.mem_addr[3:0]];
    always @(posedge clk) begin
        if (bus.mem_en === 1'b1 && bus.mem_wr === 1'b1) begin
            mem_arr[bus.mem_addr[3:0]] <= bus.mem_wdata;
        end
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // reference model state (cycle-number arithmetic)
    logic [15:0] ref_mem [16];
    logic        active = 1'b0;
    int          cur_g = -100;
    logic        cur_d, cur_wr;
    logic [15:0] cur_addr, cur_wdata, cur_rd;
    logic        last_d = 1'b0;
    logic        exp_err = 1'b0;
    logic [15:0] exp_if_data = 16'h0, exp_d_rdata = 16'h0;
    logic        e_busy, e_en, e_ifd, e_dd;

    req_t iq[$];
    req_t dq[$];
    int   obs_done[$];
    int   done_cyc[$];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    function automatic req_t mk(input logic wr, input logic [15:0] addr, input logic [15:0] wdata);
        req_t r;
        r.wr = wr;
        r.addr = addr;
        r.wdata = wdata;
        return r;
    endfunction

    task automatic check_cycle();
        int t = cyc;
        e_busy = active && (t > cur_g) && (t <= cur_g + LAT);
        e_en   = active && (t == cur_g + 1);
        e_ifd  = active && !cur_d && (t == cur_g + LAT + 1);
        e_dd   = active && cur_d && (t == cur_g + LAT + 1);
        if (e_ifd) exp_if_data = cur_rd;
        if (e_dd && !cur_wr) exp_d_rdata = cur_rd;
        chk("busy", 16'(bus.busy), 16'(e_busy));
        chk("mem_en", 16'(bus.mem_en), 16'(e_en));
        chk("mem_wr", 16'(bus.mem_wr), 16'(e_en && cur_wr));
        if (e_en) chk("mem_addr", bus.mem_addr, cur_addr);
        if (e_en && cur_wr) chk("mem_wdata", bus.mem_wdata, cur_wdata);
        chk("if_done", 16'(bus.if_done), 16'(e_ifd));
        chk("d_done", 16'(bus.d_done), 16'(e_dd));
        chk("if_data", bus.if_data, exp_if_data);
        chk("d_rdata", bus.d_rdata, exp_d_rdata);
        chk("err", 16'(bus.err), 16'(exp_err));
        if (bus.if_done === 1'b1) begin
            obs_done.push_back(0);
            done_cyc.push_back(t);
        end
        if (bus.d_done === 1'b1) obs_done.push_back(1);
    endtask

    task automatic drive();
        req_t r;
        if (e_ifd) bus.if_req = 1'b0;
        if (e_dd) bus.d_req = 1'b0;
        if (!bus.if_req && iq.size() > 0) begin
            r = iq.pop_front();
            bus.if_addr = r.addr;
            bus.if_req = 1'b1;
        end
        if (!bus.d_req && dq.size() > 0) begin
            r = dq.pop_front();
            bus.d_wr = r.wr;
            bus.d_addr = r.addr;
            bus.d_wdata = r.wdata;
            bus.d_req = 1'b1;
        end
    endtask

    task automatic commit_tick();
        int t = cyc;
        logic pick_d;
        if (!rst) begin
            active = 1'b0;
            exp_err = 1'b0;
            last_d = 1'b0;
            exp_if_data = 16'h0;
            exp_d_rdata = 16'h0;
        end else begin
            if (e_busy && ((cur_d && !bus.d_req) || (!cur_d && !bus.if_req))) exp_err = 1'b1;
            if (!e_busy && (bus.if_req || bus.d_req)) begin
`ifdef MEM_ARB_RR_EN
                pick_d = bus.d_req && (!bus.if_req || !last_d);
`else
                pick_d = bus.d_req;
`endif
                active = 1'b1;
                cur_g = t;
                cur_d = pick_d;
                last_d = pick_d;
                cur_addr = pick_d ? bus.d_addr : bus.if_addr;
                cur_wr = pick_d && bus.d_wr;
                cur_wdata = bus.d_wdata;
                if (cur_wr) ref_mem[cur_addr[3:0]] = cur_wdata;
                else cur_rd = ref_mem[cur_addr[3:0]];
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic cycle();
        check_cycle();
        drive();
        commit_tick();
    endtask

    task automatic drain();
        int n = 0;
        while (n < 500 && (iq.size() > 0 || dq.size() > 0 || bus.if_req || bus.d_req ||
                           (active && cyc <= cur_g + LAT + 1))) begin
            cycle();
            n++;
        end
        chk("drain_timeout", 16'(n >= 500), 16'h0);
    endtask

    initial begin
        int req_cyc;
        for (int i = 0; i < 16; i++) ref_mem[i] = mem_arr[i];
        rst = 1'b0;
        bus.if_req = 1'b0; bus.if_addr = 16'h0;
        bus.d_req = 1'b0; bus.d_wr = 1'b0; bus.d_addr = 16'h0; bus.d_wdata = 16'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // reset state
        chk("rst_mem_addr", bus.mem_addr, 16'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 16'h0);
        check_cycle();
        rst = 1'b1;
        commit_tick();

        // single read
        obs_done.delete(); done_cyc.delete();
        iq.push_back(mk(1'b0, 16'h0010, 16'h0));
        req_cyc = cyc;
        drain();
        chk("single_data", bus.if_data, 16'hABCD);
        chk("single_count", 16'(done_cyc.size()), 16'd1);
        if (done_cyc.size() == 1) chk("single_latency", 16'(done_cyc[0] - req_cyc), 16'(LAT + 1));

        // write then read back
        dq.push_back(mk(1'b1, 16'h0040, 16'h1234));
        drain();
        chk("write_keeps_rdata", bus.d_rdata, 16'h0000);
        dq.push_back(mk(1'b0, 16'h0040, 16'h0));
        drain();
        chk("read_after_write", bus.d_rdata, 16'h1234);

        // back-to-back fetch
        obs_done.delete(); done_cyc.delete();
        for (int i = 0; i < 3; i++) iq.push_back(mk(1'b0, 16'(16'h0021 + i), 16'h0));
        drain();
        chk("b2b_count", 16'(done_cyc.size()), 16'd3);
        if (done_cyc.size() == 3) begin
            chk("b2b_gap0", 16'(done_cyc[1] - done_cyc[0]), 16'(LAT + 1));
            chk("b2b_gap1", 16'(done_cyc[2] - done_cyc[1]), 16'(LAT + 1));
        end
        chk("b2b_last_data", bus.if_data, 16'h0303);

        // tie: both sides held continuously
        obs_done.delete();
        for (int i = 0; i < 4; i++) begin
            iq.push_back(mk(1'b0, 16'(i + 8), 16'h0));
            dq.push_back(mk(1'b0, 16'(i + 4), 16'h0));
        end
        drain();
        chk("tie_count", 16'(obs_done.size()), 16'd8);
        for (int i = 0; i < 8 && i < obs_done.size(); i++) begin
`ifdef MEM_ARB_RR_EN
            chk("tie_order", 16'(obs_done[i]), 16'((i % 2) == 0));
`else
            chk("tie_order", 16'(obs_done[i]), 16'(i < 4));
`endif
        end

        // protocol error: drop if_req during BUSY_I
        obs_done.delete();
        iq.push_back(mk(1'b0, 16'h0003, 16'h0));
        cycle();
        check_cycle();
        bus.if_req = 1'b0;
        commit_tick();
        drain();
        chk("err_done_seen", 16'(obs_done.size()), 16'd1);
        for (int i = 0; i < 3; i++) cycle();
        chk("err_sticky", 16'(bus.err), 16'd1);

        // reset in the middle of a data read
        dq.push_back(mk(1'b0, 16'h0005, 16'h0));
        cycle();
        check_cycle();
        rst = 1'b0;
        bus.d_req = 1'b0;
        commit_tick();
        chk("midrst_mem_addr", bus.mem_addr, 16'h0);
        chk("midrst_mem_wdata", bus.mem_wdata, 16'h0);
        chk("midrst_busy", 16'(bus.busy), 16'h0);
        check_cycle();
        rst = 1'b1;
        commit_tick();
        for (int i = 0; i < LAT + 2; i++) cycle();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0 && iq.size() < 2)
                iq.push_back(mk(1'b0, 16'($urandom_range(0, 31)), 16'h0));
            if ($urandom_range(0, 2) == 0 && dq.size() < 2)
                dq.push_back(mk(1'($urandom_range(0, 1)), 16'($urandom_range(0, 31)), 16'($urandom)));
            cycle();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
